// File: rtl/ram_arb_pkg.sv
// Shared constants and FSM state encoding for the RAM access arbiter.
package ram_arb_pkg;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: one-hot grant to the requester that did not win last.
module rr_arbiter_2
  import ram_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);
  always_comb begin
    grant = '0;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == PORT1) ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end
endmodule

// File: rtl/ram_access_arbiter.sv
// Round-robin sharing of one single-clock RAM between two requesters.
// Optional RAM_ARB_PERF_EN adds saturating per-port grant counters.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_read_addr,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic [DATA_W-1:0] ram_read_data
`ifdef RAM_ARB_PERF_EN
  ,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1
`endif
);
  state_t              state, state_nxt;
  logic                last_grant;
  logic [1:0]          grant;
  logic                accept;
  logic                acc_port;
  logic                lat_port;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;

  rr_arbiter_2 u_rr (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign accept   = (state == IDLE) && (|grant);
  assign acc_port = grant[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= PORT1;
      lat_port   <= PORT0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= acc_port;
        lat_port   <= acc_port;
        lat_we     <= acc_port ? req_we[1]  : req_we[0];
        lat_addr   <= acc_port ? req_addr1  : req_addr0;
        lat_wdata  <= acc_port ? req_wdata1 : req_wdata0;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    req_ready      = '0;
    rsp_valid      = '0;
    rsp_rdata      = '0;
    ram_read       = 1'b0;
    ram_write      = 1'b0;
    ram_read_addr  = '0;
    ram_write_addr = '0;
    ram_write_data = '0;
    case (state)
      IDLE: begin
        req_ready = grant;
        if (|grant) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (lat_we) begin
          ram_write      = 1'b1;
          ram_write_addr = lat_addr;
          ram_write_data = lat_wdata;
          state_nxt      = IDLE;
        end else begin
          ram_read      = 1'b1;
          ram_read_addr = lat_addr;
          state_nxt     = CAPTURE;
        end
      end
      CAPTURE: begin
        rsp_valid[lat_port] = 1'b1;
        rsp_rdata           = ram_read_data;
        state_nxt           = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Outputs are forced low while reset is held so an interrupted response never pulses.
    if (reset) begin
      req_ready      = '0;
      rsp_valid      = '0;
      rsp_rdata      = '0;
      ram_read       = 1'b0;
      ram_write      = 1'b0;
      ram_read_addr  = '0;
      ram_write_addr = '0;
      ram_write_data = '0;
    end
  end

`ifdef RAM_ARB_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (accept) begin
      if (!acc_port && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (acc_port && grant_cnt1 != '1)  grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif
endmodule
